// File: rtl/elastic_pipe_stage.sv
// Elastic bank of DEPTH registered stages, each with a valid bit, flush and per-stage kill.
// Latency: an entry loaded into stage 0 at edge t reaches the output at edge t+DEPTH-1.
// Backpressure: ready ripples combinationally from out_ready; only full stages stall.
module elastic_pipe_stage #(
    parameter int unsigned      WIDTH   = 32,
    parameter int unsigned      DEPTH   = 1,
    parameter logic [WIDTH-1:0] CLR_VAL = '0,
    localparam int unsigned     CW      = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sclr,
    input  logic [DEPTH-1:0] kill,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [DEPTH-1:0] stage_valid,
    output logic [CW-1:0]    count
);

    logic [DEPTH-1:0] stage_vld;
    logic [WIDTH-1:0] stage_dat [DEPTH];

    logic [DEPTH-1:0] ev;
    logic [DEPTH-1:0] adv;
    logic [DEPTH-1:0] up;
    logic [DEPTH:0]   rdy;
    logic [WIDTH-1:0] dat_up [DEPTH];

    // Ready chain is resolved from the output end so a draining tail frees the whole bank in one cycle.
    always_comb begin
        ev         = stage_vld & ~kill;
        up         = DEPTH'({ev, in_valid});
        adv        = '0;
        rdy        = '0;
        rdy[DEPTH] = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            adv[i] = ev[i] & rdy[i+1];
            rdy[i] = ~ev[i] | adv[i];
        end
    end

    always_comb begin
        dat_up[0] = in_data;
        for (int i = 1; i < DEPTH; i++) begin
            dat_up[i] = stage_dat[i-1];
        end
    end

    // A bubble moving in leaves the data register untouched.
    always_ff @(posedge clk) begin
        if (rst || sclr) begin
            stage_vld <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                stage_dat[i] <= CLR_VAL;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (rdy[i]) begin
                    stage_vld[i] <= up[i];
                    if (up[i]) begin
                        stage_dat[i] <= dat_up[i];
                    end
                end
            end
        end
    end

    always_comb begin
        count = '0;
        for (int i = 0; i < DEPTH; i++) begin
            count = count + CW'(stage_vld[i]);
        end
    end

    assign in_ready    = rdy[0] & ~sclr & ~rst;
    assign out_valid   = ev[DEPTH-1] & ~sclr & ~rst;
    assign out_data    = stage_dat[DEPTH-1];
    assign stage_valid = stage_vld;

endmodule

// File: tb/tb_elastic_pipe_stage.sv
// Randomised and directed bench for elastic_pipe_stage against an entry-list reference model.
module tb_elastic_pipe_stage;

    localparam int          W   = 16;
    localparam int          D   = 3;
    localparam int          CWT = $clog2(D + 1);
    localparam logic [W-1:0] CLR = 16'hC1A0;

    logic           clk;
    logic           rst;
    logic           sclr;
    logic [D-1:0]   kill;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_data;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_data;
    logic [D-1:0]   stage_valid;
    logic [CWT-1:0] count;

    elastic_pipe_stage #(.WIDTH(W), .DEPTH(D), .CLR_VAL(CLR)) dut (
        .clk(clk), .rst(rst), .sclr(sclr), .kill(kill),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .stage_valid(stage_valid), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { int id; logic [W-1:0] d; int pos; } ent_t;
    typedef struct { int id; logic [W-1:0] d; } exp_t;

    ent_t         ents[$];     // occupied stages, oldest first
    exp_t         expq[$];     // accepted entries in acceptance order
    bit           killed[int];
    logic [W-1:0] last_dat;
    int           checks = 0;
    int           errors = 0;
    int           next_id = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, check registered and combinational outputs, advance the model.
    task automatic step(input bit iv, input logic [W-1:0] d, input bit ordy,
                        input logic [D-1:0] k, input bit sc, input bit rs);
        logic [D-1:0] sv;
        ent_t         alive[$];
        ent_t         nxt[$];
        ent_t         e;
        bit           ov, ir;
        int           prev, np;
        logic [W-1:0] new_last;
        in_valid = iv; in_data = d; out_ready = ordy; kill = k; sclr = sc; rst = rs;
        @(negedge clk);
        sv = '0;
        foreach (ents[i]) sv[ents[i].pos] = 1'b1;
        check("stage_valid", 32'(stage_valid), 32'(sv));
        check("count", 32'(count), 32'(ents.size()));
        check("out_data_reg", 32'(out_data), 32'(last_dat));
        foreach (ents[i]) begin
            if (k[ents[i].pos]) killed[ents[i].id] = 1'b1;
            else alive.push_back(ents[i]);
        end
        ov = !rs && !sc && alive.size() > 0 && alive[0].pos == D - 1;
        prev = D;
        new_last = last_dat;
        foreach (alive[i]) begin
            if (alive[i].pos == D - 1 && ordy) continue;
            np = (alive[i].pos + 1 < prev) ? alive[i].pos + 1 : alive[i].pos;
            if (np == D - 1 && np != alive[i].pos) new_last = alive[i].d;
            e = alive[i];
            e.pos = np;
            nxt.push_back(e);
            prev = np;
        end
        ir = !rs && !sc && prev > 0;
        check("out_valid", 32'(out_valid), 32'(ov));
        check("in_ready", 32'(in_ready), 32'(ir));
        if (rs || sc) begin
            foreach (ents[i]) killed[ents[i].id] = 1'b1;
            ents.delete();
            last_dat = CLR;
        end else begin
            ents = nxt;
            last_dat = new_last;
            if (iv && ir) begin
                e.id = next_id; e.d = d; e.pos = 0;
                ents.push_back(e);
                expq.push_back('{id: next_id, d: d});
                if (D == 1) last_dat = d;
                next_id++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Output monitor: every DUT output transfer must be the oldest surviving accepted entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                while (expq.size() > 0 && killed.exists(expq[0].id)) void'(expq.pop_front());
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL out_order: got output %0h expected no output", out_data);
                end else begin
                    e = expq.pop_front();
                    check("out_order", 32'(out_data), 32'(e.d));
                end
            end
        end
    end

    initial begin
        int leftover;
        rst = 1'b1; sclr = 1'b0; kill = '0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        @(posedge clk);
        #1;
        last_dat = CLR;
        step(1, 16'h0BAD, 1, '0, 0, 1);

        // throughput
        step(1, 16'h11, 1, '0, 0, 0);
        step(1, 16'h22, 1, '0, 0, 0);
        step(1, 16'h33, 1, '0, 0, 0);
        repeat (4) step(0, 16'h0, 1, '0, 0, 0);

        // back-pressure, then simultaneous load and drain
        for (int i = 0; i < 6; i++) step(1, 16'(16'h44 + 16'(i)), 0, '0, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 16'(16'h70 + 16'(i)), 1, '0, 0, 0);
        repeat (4) step(0, 16'h0, 1, '0, 0, 0);

        // bubble collapse
        step(1, 16'hA5, 0, '0, 0, 0);
        repeat (4) step(0, 16'h0, 0, '0, 0, 0);
        repeat (2) step(0, 16'h0, 1, '0, 0, 0);

        // kill the middle entry of a full stalled bank
        step(1, 16'h1, 0, '0, 0, 0);
        step(1, 16'h2, 0, '0, 0, 0);
        step(1, 16'h3, 0, '0, 0, 0);
        step(0, 16'h0, 0, 3'b010, 0, 0);
        repeat (4) step(0, 16'h0, 1, '0, 0, 0);

        // flush a full bank while input is offered
        for (int i = 0; i < 3; i++) step(1, 16'(16'h50 + 16'(i)), 0, '0, 0, 0);
        step(1, 16'h99, 0, '0, 1, 0);
        step(0, 16'h0, 1, '0, 0, 0);

        // reset mid-stream
        for (int i = 0; i < 4; i++) step(1, 16'(16'h60 + 16'(i)), 1, '0, 0, 0);
        step(1, 16'h6A, 1, '0, 0, 1);
        step(1, 16'h6B, 1, '0, 0, 1);
        for (int i = 0; i < 5; i++) step(1, 16'(16'h80 + 16'(i)), 1, '0, 0, 0);

        for (int n = 0; n < 600; n++) begin
            step($urandom % 4 != 0, 16'($urandom), $urandom % 3 != 0,
                 ($urandom % 8 == 0) ? D'($urandom) : '0,
                 $urandom % 60 == 0, $urandom % 120 == 0);
        end

        repeat (D + 3) step(0, 16'h0, 1, '0, 0, 0);
        leftover = 0;
        foreach (expq[i]) if (!killed.exists(expq[i].id)) leftover++;
        check("leftover_entries", 32'(leftover), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
